// File: rtl/frame_pkg.sv
// Shared frame definitions: sequencer states and frame geometry.
package frame_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        AXI_WRITE = 2'd1,
        RGB_BUSY  = 2'd2,
        AXI_READ  = 2'd3
    } state_t;

    localparam int FRAME_W      = 320;
    localparam int FRAME_H      = 240;
    localparam int FRAME_PIXELS = FRAME_W * FRAME_H;
    localparam int ADDR_W       = 17;

endpackage

// File: rtl/frame_read_counter.sv
// Modulo-N counter with synchronous clear; tc flags the accepted count that wraps.
module frame_read_counter #(
    parameter int N = 76800,
    parameter int W = 17
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         tc
);

    // Terminal count is combinational so the owner can act in the same cycle.
    always_comb begin
        tc = en && (cnt == W'(N - 1));
    end

    // Count accepted events, wrapping back to zero on the terminal one.
    always_ff @(posedge clk) begin
        if (!rst_n || clr)
            cnt <= '0;
        else if (en)
            cnt <= tc ? '0 : cnt + W'(1);
    end

endmodule

// File: rtl/frame_bram_sequencer.sv
// Frame lifecycle sequencer and BRAM port arbiter between the AXI bridge and the gray engine.
module frame_bram_sequencer #(
    parameter int FRAME_PIXELS = frame_pkg::FRAME_PIXELS,
    parameter int ADDR_W       = frame_pkg::ADDR_W,
    parameter int WDOG_CYCLES  = 2000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              axi_color_write,
    input  logic              axi_color_read,
    input  logic [ADDR_W-1:0] axi_color_addr,
    input  logic              axi_gray_read,
    input  logic [ADDR_W-1:0] axi_gray_addr,
    input  logic              eng_color_read,
    input  logic [ADDR_W-1:0] eng_color_addr,
    input  logic [ADDR_W-1:0] eng_gray_wr_addr,
    input  logic              done_write_color,
    input  logic              done_write_gray,
    output logic              color_write,
    output logic              color_read,
    output logic [ADDR_W-1:0] color_addr,
    output logic              gray_read,
    output logic [ADDR_W-1:0] gray_addr,
    output logic              busy,
    output logic              frame_done,
    output logic              wdog_err,
    output logic [1:0]        state_o
);

    import frame_pkg::*;

    state_t            state, state_next;
    logic              start_q;
    logic              start_edge;
    logic [31:0]       wdog_cnt;
    logic              wdog_expire;
    logic [ADDR_W-1:0] rd_cnt;
    logic              rd_tc;
    logic              rd_clr;

    assign start_edge  = start & ~start_q;
    assign wdog_expire = (state == RGB_BUSY) && (wdog_cnt == 32'(WDOG_CYCLES - 1));
    assign rd_clr      = (state_next == AXI_READ) && (state != AXI_READ);

    // Gray read-back counter; only gated reads count, so it advances only in AXI_READ.
    frame_read_counter #(
        .N (FRAME_PIXELS),
        .W (ADDR_W)
    ) u_rd_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (rd_clr),
        .en    (gray_read),
        .cnt   (rd_cnt),
        .tc    (rd_tc)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next-state logic; done_write_gray beats a simultaneous watchdog expiry.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (start_edge)       state_next = AXI_WRITE;
            AXI_WRITE: if (done_write_color) state_next = RGB_BUSY;
            RGB_BUSY: begin
                if (done_write_gray)         state_next = AXI_READ;
                else if (wdog_expire)        state_next = IDLE;
            end
            AXI_READ:  if (rd_tc)            state_next = IDLE;
            default:                         state_next = IDLE;
        endcase
    end

    // Port steering from the registered state: engine owns the ports only in RGB_BUSY.
    always_comb begin
        color_write = (state == AXI_WRITE) && axi_color_write;
        gray_read   = (state == AXI_READ) && axi_gray_read;
        color_read  = axi_color_read;
        color_addr  = axi_color_addr;
        gray_addr   = axi_gray_addr;
        if (state == RGB_BUSY) begin
            color_read = eng_color_read;
            color_addr = eng_color_addr;
            gray_addr  = eng_gray_wr_addr;
        end
    end

    // Edge detector, watchdog, completion pulse and sticky error flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            start_q    <= 1'b0;
            wdog_cnt   <= '0;
            frame_done <= 1'b0;
            wdog_err   <= 1'b0;
        end else begin
            start_q    <= start;
            frame_done <= (state == AXI_READ) && rd_tc;
            if (state_next == RGB_BUSY && state != RGB_BUSY)
                wdog_cnt <= '0;
            else if (state == RGB_BUSY)
                wdog_cnt <= wdog_cnt + 32'd1;
            if (wdog_expire && !done_write_gray)
                wdog_err <= 1'b1;
            else if (state == IDLE && start_edge)
                wdog_err <= 1'b0;
        end
    end

    assign busy    = (state != IDLE);
    assign state_o = state;

endmodule

// File: tb/tb_frame_bram_sequencer.sv
// Directed bench for frame_bram_sequencer: full frame, gating, watchdog and reset cases.
module tb_frame_bram_sequencer;

    localparam int AW = 17;
    localparam int NP = 76800;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          axi_color_write, axi_color_read;
    logic [AW-1:0] axi_color_addr;
    logic          axi_gray_read;
    logic [AW-1:0] axi_gray_addr;
    logic          eng_color_read;
    logic [AW-1:0] eng_color_addr, eng_gray_wr_addr;
    logic          done_write_color, done_write_gray;
    logic          color_write, color_read, gray_read;
    logic [AW-1:0] color_addr, gray_addr;
    logic          busy, frame_done, wdog_err;
    logic [1:0]    state_o;

    int n_cmp = 0;
    int n_err = 0;

    frame_bram_sequencer #(
        .FRAME_PIXELS (NP),
        .ADDR_W       (AW),
        .WDOG_CYCLES  (100)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .axi_color_write  (axi_color_write),
        .axi_color_read   (axi_color_read),
        .axi_color_addr   (axi_color_addr),
        .axi_gray_read    (axi_gray_read),
        .axi_gray_addr    (axi_gray_addr),
        .eng_color_read   (eng_color_read),
        .eng_color_addr   (eng_color_addr),
        .eng_gray_wr_addr (eng_gray_wr_addr),
        .done_write_color (done_write_color),
        .done_write_gray  (done_write_gray),
        .color_write      (color_write),
        .color_read       (color_read),
        .color_addr       (color_addr),
        .gray_read        (gray_read),
        .gray_addr        (gray_addr),
        .busy             (busy),
        .frame_done       (frame_done),
        .wdog_err         (wdog_err),
        .state_o          (state_o)
    );

    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0;
        axi_color_write = 1'b1; axi_color_read = 1'b1; axi_color_addr = 17'h00aa;
        axi_gray_read = 1'b1; axi_gray_addr = 17'h00bb;
        eng_color_read = 1'b0; eng_color_addr = 17'h00123; eng_gray_wr_addr = 17'h00456;
        done_write_color = 1'b0; done_write_gray = 1'b0;
        tick(2);
        // Reset state: AXI side selected, strobes gated off.
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cwrite", 32'(color_write), 32'd0);
        chk("rst_gread", 32'(gray_read), 32'd0);
        chk("rst_caddr", 32'(color_addr), 32'h00aa);
        chk("rst_cread", 32'(color_read), 32'd1);
        chk("rst_gaddr", 32'(gray_addr), 32'h00bb);
        chk("rst_fdone", 32'(frame_done), 32'd0);
        chk("rst_werr", 32'(wdog_err), 32'd0);

        rst_n = 1'b1; axi_color_write = 1'b0; axi_color_read = 1'b0; axi_gray_read = 1'b0;
        tick(1);
        chk("idle_hold", 32'(state_o), 32'd0);
        start = 1'b1;
        tick(1);
        chk("start_edge", 32'(state_o), 32'd1);
        chk("busy_w", 32'(busy), 32'd1);

        // AXI_WRITE: colour writes pass, stray gray-done is ignored.
        axi_color_write = 1'b1; axi_color_addr = 17'd7; #1;
        chk("w_cwrite", 32'(color_write), 32'd1);
        chk("w_caddr", 32'(color_addr), 32'd7);
        done_write_gray = 1'b1;
        tick(3);
        done_write_gray = 1'b0;
        chk("w_ign_gdone", 32'(state_o), 32'd1);
        axi_color_write = 1'b0; done_write_color = 1'b1;
        tick(1);
        done_write_color = 1'b0;
        chk("to_rgb", 32'(state_o), 32'd2);

        // RGB_BUSY: engine owns colour read and gray address; AXI writes blocked.
        eng_color_read = 1'b1; axi_color_write = 1'b1; axi_color_addr = 17'd5; #1;
        chk("r_caddr", 32'(color_addr), 32'h00123);
        chk("r_cread", 32'(color_read), 32'd1);
        chk("r_cwrite", 32'(color_write), 32'd0);
        chk("r_gaddr", 32'(gray_addr), 32'h00456);
        tick(2);
        axi_color_write = 1'b0; eng_color_read = 1'b0; done_write_gray = 1'b1;
        tick(1);
        done_write_gray = 1'b0;
        chk("to_read", 32'(state_o), 32'd3);
        chk("rd_gaddr", 32'(gray_addr), 32'h00bb);
        chk("rd_caddr", 32'(color_addr), 32'd5);

        // Full read-back with start held high the whole time.
        axi_gray_read = 1'b1; #1;
        chk("rd_gread", 32'(gray_read), 32'd1);
        tick(NP - 1);
        chk("rd_76799_state", 32'(state_o), 32'd3);
        chk("rd_76799_fdone", 32'(frame_done), 32'd0);
        chk("rd_76799_cnt", 32'(dut.rd_cnt), 32'(NP - 1));
        tick(1);
        axi_gray_read = 1'b0;
        chk("fin_state", 32'(state_o), 32'd0);
        chk("fin_fdone", 32'(frame_done), 32'd1);
        chk("fin_cnt", 32'(dut.rd_cnt), 32'd0);
        tick(1);
        chk("fdone_1cyc", 32'(frame_done), 32'd0);
        tick(3);
        chk("no_retrig", 32'(state_o), 32'd0);

        // New edge after start drops, then let the watchdog expire.
        start = 1'b0; tick(1);
        start = 1'b1; tick(1);
        chk("retrig", 32'(state_o), 32'd1);
        done_write_color = 1'b1; tick(1); done_write_color = 1'b0;
        chk("wd_entry", 32'(state_o), 32'd2);
        tick(99);
        chk("wd_99", 32'(state_o), 32'd2);
        chk("wd_99_err", 32'(wdog_err), 32'd0);
        tick(1);
        chk("wd_exp_state", 32'(state_o), 32'd0);
        chk("wd_exp_err", 32'(wdog_err), 32'd1);
        chk("wd_exp_fdone", 32'(frame_done), 32'd0);
        tick(2);
        chk("wd_sticky", 32'(wdog_err), 32'd1);
        start = 1'b0; tick(1);
        start = 1'b1; tick(1);
        chk("wd_clr_state", 32'(state_o), 32'd1);
        chk("wd_clr_err", 32'(wdog_err), 32'd0);

        // done_write_gray on the expiry cycle wins.
        done_write_color = 1'b1; tick(1); done_write_color = 1'b0;
        tick(99);
        done_write_gray = 1'b1; tick(1); done_write_gray = 1'b0;
        chk("race_state", 32'(state_o), 32'd3);
        chk("race_err", 32'(wdog_err), 32'd0);

        // Reset during AXI_READ clears the read counter.
        axi_gray_read = 1'b1; tick(3); axi_gray_read = 1'b0;
        chk("mid_rd_cnt", 32'(dut.rd_cnt), 32'd3);
        rst_n = 1'b0; tick(1);
        chk("rst_rd_state", 32'(state_o), 32'd0);
        chk("rst_rd_cnt", 32'(dut.rd_cnt), 32'd0);

        // Reset during RGB_BUSY.
        start = 1'b0; rst_n = 1'b1; tick(1);
        start = 1'b1; tick(1);
        done_write_color = 1'b1; tick(1); done_write_color = 1'b0;
        tick(5);
        chk("mid_rgb_wd", dut.wdog_cnt, 32'd5);
        rst_n = 1'b0; tick(1);
        chk("rst_rgb_state", 32'(state_o), 32'd0);
        chk("rst_rgb_busy", 32'(busy), 32'd0);
        chk("rst_rgb_caddr", 32'(color_addr), 32'd5);
        chk("rst_rgb_gaddr", 32'(gray_addr), 32'h00bb);
        chk("rst_rgb_wd", dut.wdog_cnt, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
